bram_sqp_arbiter: RTL and testbench
===================================

// Module: bram_sqp_arbiter
// PURPOSE
//  Shares one bram_sqp (2 write + 2 read ports, shared array) among NREQ requesters.
//  Round-robin grants up to two requests per cycle, one per physical port.
//  Blocks same-cycle address hazards between ports and routes read data back to the issuer.
//  Sits between pixel/sprite/CPU-side engines and a shared buffer.
// PARAMETERS
//  NREQ   4      number of requesters (2..8)
//  WIDTH  8      data width, passed to bram_sqp
//  DEPTH  256    words, passed to bram_sqp; AW = $clog2(DEPTH)
//  INIT_F ""     memory init file, passed to bram_sqp
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active high
//  req_valid  in   NREQ         request pending, per requester
//  req_we     in   NREQ         1 = write, 0 = read
//  req_addr   in   NREQ x AW    word address
//  req_data   in   NREQ x WIDTH write data
//  req_ready  out  NREQ         request accepted this cycle (combinational grant)
//  rsp_valid  out  NREQ         read data valid, one pulse per accepted read
//  rsp_data   out  NREQ x WIDTH read data; don't-care when rsp_valid=0
// BEHAVIOUR
//  - Handshake: transfer when req_valid & req_ready in the same cycle.
//    req_valid must not depend on req_ready.
//    Requester holds valid, we, addr and data stable until accepted.
//  - Reset: rr_ptr=0; rsp_valid=0; req_ready=0 while rst=1. Memory contents not cleared.
//  - Grant, each cycle:
//    - Scan from rr_ptr, wrapping NREQ-1 -> 0. First valid -> port 0, second valid -> port 1.
//    - Grant to port 1 is withheld (the requester waits) if:
//      - both are writes to the same addr, or
//      - one writes the addr the other reads (no read-during-write on the array).
//    - Withheld candidate is not replaced by a later requester that cycle.
//  - Pointer: rr_ptr <= (index of last granted requester + 1) mod NREQ; unchanged if no grant.
//    Fairness: a continuously valid requester is granted within NREQ cycles.
//  - Port drive: granted write -> we_n=1, addr_write_n, data_in_n.
//    Granted read -> addr_read_n; we_n=0 for any non-write grant.
//  - Read latency 1: grant at cycle N -> rsp_valid[i]=1 and rsp_data[i] at N+1.
//    Port and requester index registered at grant.
//    Back-to-back reads give one rsp pulse per cycle.
//  - Writes produce no response; data is visible to reads granted from the next cycle.
//  - Same requester never granted both ports in one cycle.
//  - rst asserted mid-operation: rsp_valid=0 the following cycle. Reads granted in the cycle
//    before rst are dropped without response; a write granted that cycle completes.
//  - NREQ not a power of two: pointer wrap uses an explicit compare, never a bit-slice.
// STRUCTURE
//  - Package bram_arb_pkg: typedef port_sel_t (PORT0/PORT1); function rr_next().
//  - One sub-module: bram_sqp, instantiated once with WIDTH/DEPTH/INIT_F passthrough.
//    Arbiter logic stays in this file.
//  - Registers: rr_ptr, rsp_pend[2] {valid, req_idx}.
// TESTING
//  1. Reset: rst=1 for 3 cycles, all req_valid=1
//     -> req_ready=0 and rsp_valid=0 throughout; after release req0 -> port 0, req1 -> port 1.
//  2. Write then read: req0 writes 0xA5 @0x10 at cycle N; req0 reads 0x10 at N+1
//     -> rsp_valid[0]=1, rsp_data=0xA5 at N+2.
//  3. Same-addr hazard: req1 writes @0x20, req2 reads @0x20 in the same cycle, rr_ptr=1
//     -> only req1 ready; req2 granted next cycle, reads new value.
//  4. Fairness: all 4 requesters hold valid reads for 8 cycles
//     -> grant pairs {0,1},{2,3},{0,1},...; each requester receives 4 responses.
//  5. Dual write/read: req0 writes @1, req3 reads @2 in the same cycle
//     -> both ready; rsp_valid[3]=1 next cycle with mem[2].
//  6. Reset mid-read: grant req2 read at N, rst=1 at N
//     -> rsp_valid=0 at N+1; after release req2 reissues and is served normally.

Source files
------------

// File: rtl/bram_sqp_arbiter_pkg.sv
// Shared types and helpers for the bram_sqp request arbiter.
package bram_arb_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_t;

  typedef struct packed {
    logic vld;
    idx_t idx;
  } rsp_pend_t;

  // Round-robin successor. The wrap is an explicit compare so non-power-of-two counts work.
  function automatic idx_t rr_next(input idx_t cur, input int nreq);
    if (int'(cur) >= nreq - 1) return '0;
    return cur + idx_t'(1);
  endfunction

endpackage

// File: rtl/bram_sqp.sv
// Two-write / two-read block RAM on one shared array, with a registered read (latency 1).
module bram_sqp #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter     INIT_F = "",
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [AW-1:0]    addr_write0,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [AW-1:0]    addr_read0,
  output logic [WIDTH-1:0] data_out0,
  input  logic             we1,
  input  logic [AW-1:0]    addr_write1,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [AW-1:0]    addr_read1,
  output logic [WIDTH-1:0] data_out1
);

  // INIT_F is carried for interface compatibility; this model does not preload contents.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[addr_write0] <= data_in0;
    if (we1) mem[addr_write1] <= data_in1;
    data_out0 <= mem[addr_read0];
    data_out1 <= mem[addr_read1];
  end

endmodule

// File: rtl/bram_sqp_arbiter.sv
// Round-robin arbiter sharing one bram_sqp among NREQ requesters, two grants per cycle.
module bram_sqp_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter     INIT_F = "",
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ-1:0][AW-1:0]    req_addr,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [NREQ-1:0][WIDTH-1:0] rsp_data
);

  idx_t             rr_ptr;
  logic             found0, found1;
  idx_t             c0, c1;
  logic             we_c0, we_c1;
  logic [AW-1:0]    addr_c0, addr_c1;
  logic [WIDTH-1:0] data_c0, data_c1;
  logic             hazard, g0, g1;
  idx_t             last_grant;
  logic [WIDTH-1:0] dout0, dout1;
  rsp_pend_t        rsp_pend_p1 [2];

  // Scan from rr_ptr; position rr_ptr+k maps to requester i when it equals i or i+NREQ.
  always_comb begin
    found0  = 1'b0;
    found1  = 1'b0;
    c0      = '0;
    c1      = '0;
    we_c0   = 1'b0;
    we_c1   = 1'b0;
    addr_c0 = '0;
    addr_c1 = '0;
    data_c0 = '0;
    data_c1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NREQ)) && req_valid[i]) begin
          if (!found0) begin
            found0  = 1'b1;
            c0      = idx_t'(i);
            we_c0   = req_we[i];
            addr_c0 = req_addr[i];
            data_c0 = req_data[i];
          end else if (!found1) begin
            found1  = 1'b1;
            c1      = idx_t'(i);
            we_c1   = req_we[i];
            addr_c1 = req_addr[i];
            data_c1 = req_data[i];
          end
        end
      end
    end
  end

  // Second candidate waits on any same-address pair involving a write; it is not replaced.
  always_comb begin
    hazard     = (addr_c0 == addr_c1) && (we_c0 || we_c1);
    g0         = found0 && !rst;
    g1         = found1 && !hazard && !rst;
    last_grant = g1 ? c1 : c0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (g0 && (c0 == idx_t'(i))) || (g1 && (c1 == idx_t'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (g0) begin
      rr_ptr <= rr_next(last_grant, NREQ);
    end
  end

  bram_sqp #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .INIT_F (INIT_F)
  ) u_bram (
    .clk         (clk),
    .we0         (g0 && we_c0),
    .addr_write0 (addr_c0),
    .data_in0    (data_c0),
    .addr_read0  (addr_c0),
    .data_out0   (dout0),
    .we1         (g1 && we_c1),
    .addr_write1 (addr_c1),
    .data_in1    (data_c1),
    .addr_read1  (addr_c1),
    .data_out1   (dout1)
  );

  // Stage p1: remember which requester each port's read belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_p1[PORT0].vld <= 1'b0;
      rsp_pend_p1[PORT1].vld <= 1'b0;
    end else begin
      rsp_pend_p1[PORT0].vld <= g0 && !we_c0;
      rsp_pend_p1[PORT1].vld <= g1 && !we_c1;
    end
    rsp_pend_p1[PORT0].idx <= c0;
    rsp_pend_p1[PORT1].idx <= c1;
  end

  // rst masks responses immediately, so a read granted just before reset is dropped.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = 1'b0;
      rsp_data[i]  = dout0;
      if (rsp_pend_p1[PORT0].vld && (rsp_pend_p1[PORT0].idx == idx_t'(i))) begin
        rsp_valid[i] = !rst;
      end else if (rsp_pend_p1[PORT1].vld && (rsp_pend_p1[PORT1].idx == idx_t'(i))) begin
        rsp_valid[i] = !rst;
        rsp_data[i]  = dout1;
      end
    end
  end

endmodule

// File: tb/tb_bram_sqp_arbiter.sv
// Directed bench for bram_sqp_arbiter with a response scoreboard and a memory model.
module tb_bram_sqp_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_we;
  logic [NREQ-1:0][AW-1:0]    req_addr;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0][WIDTH-1:0] rsp_data;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mem_m [DEPTH];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         rsp_cnt [NREQ];

  bram_sqp_arbiter #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .INIT_F ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_data[i]  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Called just after a rising edge with this cycle's inputs driven; checks at the falling edge.
  task automatic cycle(input logic [NREQ-1:0] exp_rdy, input string tag);
    logic [NREQ-1:0] exp_v;
    exp_t e;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    exp_v = '0;
    if (rst) sb.delete();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_v[e.idx] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (i == e.idx) chk({tag, ".rsp_data"}, 32'(rsp_data[i]), 32'(e.data));
    end
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_v));
    for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rsp_cnt[i]++;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i] && !req_we[i]) begin
        e.idx  = i;
        e.data = mem_m[req_addr[i]];
        sb.push_back(e);
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (exp_rdy[i] && req_we[i]) mem_m[req_addr[i]] = req_data[i];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
    @(posedge clk);
    #1;

    // Reset held with every requester valid.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 8'(i), 8'(8'h30 + i));
    repeat (3) cycle(4'b0000, "reset");
    rst = 1'b0;
    cycle(4'b0011, "release01");
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(4'b1100, "release23");
    clear_all();
    cycle(4'b0000, "idle0");

    // Write then read back by the same requester.
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    cycle(4'b0001, "wr_a5");
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    cycle(4'b0001, "rd_a5");
    clear_all();
    cycle(4'b0000, "rsp_a5");

    // Write/read hazard on the same address, rr_ptr at 1.
    set_req(1, 1'b1, 1'b1, 8'h20, 8'h5C);
    set_req(2, 1'b1, 1'b0, 8'h20, 8'h00);
    cycle(4'b0010, "haz_wr");
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(4'b0100, "haz_rd");
    clear_all();
    cycle(4'b0000, "haz_rsp");

    // Concurrent write and read on different addresses.
    set_req(0, 1'b1, 1'b1, 8'h01, 8'h11);
    set_req(3, 1'b1, 1'b0, 8'h02, 8'h00);
    cycle(4'b1001, "dual");
    clear_all();
    cycle(4'b0000, "dual_rsp");

    // Move the pointer back to requester 0.
    set_req(3, 1'b1, 1'b0, 8'h03, 8'h00);
    cycle(4'b1000, "align");

    // Fairness: all four hold reads for eight cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 8'(i), 8'h00);
    cycle(4'b0011, "fair0");
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
    for (int k = 1; k < 8; k++) cycle((k % 2 == 1) ? 4'b1100 : 4'b0011, "fair");
    clear_all();
    cycle(4'b0000, "fair_end");
    for (int i = 0; i < NREQ; i++) chk("fair_count", 32'(rsp_cnt[i]), 32'd4);

    // Reset right after a read grant drops the response; the reissue is served.
    set_req(2, 1'b1, 1'b0, 8'h02, 8'h00);
    cycle(4'b0100, "pre_rst");
    rst = 1'b1;
    cycle(4'b0000, "mid_rst");
    rst = 1'b0;
    cycle(4'b0100, "reissue");
    clear_all();
    cycle(4'b0000, "reissue_rsp");

    // Two writes to one address serialize; two reads of one address go together.
    set_req(3, 1'b1, 1'b1, 8'h05, 8'h55);
    set_req(0, 1'b1, 1'b1, 8'h05, 8'h66);
    cycle(4'b1000, "ww_first");
    set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(4'b0001, "ww_second");
    clear_all();
    set_req(1, 1'b1, 1'b0, 8'h05, 8'h00);
    cycle(4'b0010, "ww_rd");
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(2, 1'b1, 1'b0, 8'h05, 8'h00);
    set_req(3, 1'b1, 1'b0, 8'h05, 8'h00);
    cycle(4'b1100, "rr_same");
    clear_all();
    cycle(4'b0000, "rr_rsp");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
